// File: rtl/poly_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module      : poly_voice_mixer
// Description : Polyphonic jingle mixer. Fetches one sample per active voice
//               from a shared ROM, sums them into stereo accumulators per pan,
//               applies master volume with saturation and writes one {L,R}
//               pair per frame into the DAC FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_voice_mixer #(
    parameter int VOICE_CNT    = 4,
    parameter int JINGLE_CNT   = 8,
    parameter int JINGLE_LEN   = 4096,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ROM_LAT      = 2,
    parameter int VOL_W        = 7,
    localparam int VIW = (VOICE_CNT  > 1) ? $clog2(VOICE_CNT)  : 1,
    localparam int JW  = (JINGLE_CNT > 1) ? $clog2(JINGLE_CNT) : 1,
    localparam int AW  = $clog2(JINGLE_CNT * JINGLE_LEN)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      audio_ena_i,
    input  logic                      note_on_i,
    input  logic                      note_off_i,
    input  logic [VIW-1:0]            note_voice_i,
    input  logic [JW-1:0]             note_jingle_i,
    input  logic                      note_loop_i,
    input  logic [1:0]                note_pan_i,
    input  logic [VOL_W-1:0]          volume_i,
    output logic                      rom_rd_o,
    output logic [AW-1:0]             rom_addr_o,
    input  logic [SAMPLE_WIDTH-1:0]   rom_data_i,
    input  logic                      dac_fifo_almfull_i,
    output logic                      samp_wr_req_o,
    output logic [2*SAMPLE_WIDTH-1:0] lr_chan_data_o,
    output logic [VOICE_CNT-1:0]      voice_active_o,
    output logic                      busy_o
);

    localparam int OW      = (JINGLE_LEN > 1) ? $clog2(JINGLE_LEN) : 1;
    localparam int ACC_W   = SAMPLE_WIDTH + $clog2(VOICE_CNT) + 1;
    localparam int PRD_W   = ACC_W + VOL_W + 1;
    localparam int CNT_MAX = (VOICE_CNT > ROM_LAT) ? VOICE_CNT : ROM_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic signed [PRD_W-1:0] SAT_MAX = PRD_W'((2 ** (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [PRD_W-1:0] SAT_MIN = -SAT_MAX - PRD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_SCALE = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [JW-1:0]             jingle    [VOICE_CNT];
    logic [OW-1:0]             offset    [VOICE_CNT];
    logic [1:0]                pan       [VOICE_CNT];
    logic [VOICE_CNT-1:0]      loop_mode;
    logic [VOICE_CNT-1:0]      active;
    logic [ROM_LAT-1:0]        tag_vld;
    logic [1:0]                tag_pan   [ROM_LAT];
    logic signed [ACC_W-1:0]   acc_l, acc_r;
    logic [SAMPLE_WIDTH-1:0]   out_l, out_r;

    logic [VIW-1:0]            slot;
    logic                      fetch_rd;
    logic signed [ACC_W-1:0]   samp_ext;
    logic signed [PRD_W-1:0]   vol_ext, prod_l, prod_r, shr_l, shr_r;

    // Clamp a scaled value into the signed sample range.
    function automatic logic [SAMPLE_WIDTH-1:0] sat(input logic signed [PRD_W-1:0] x);
        if (x > SAT_MAX)      sat = SAT_MAX[SAMPLE_WIDTH-1:0];
        else if (x < SAT_MIN) sat = SAT_MIN[SAMPLE_WIDTH-1:0];
        else                  sat = x[SAMPLE_WIDTH-1:0];
    endfunction

    assign slot           = cnt[VIW-1:0];
    assign fetch_rd       = (state == S_FETCH) && active[slot];
    assign rom_rd_o       = fetch_rd;
    assign rom_addr_o     = fetch_rd ? AW'({jingle[slot], offset[slot]}) : '0;
    assign samp_wr_req_o  = (state == S_WRITE);
    assign lr_chan_data_o = {out_l, out_r};
    assign voice_active_o = active;
    assign busy_o         = (state != S_IDLE);
    assign samp_ext       = {{(ACC_W-SAMPLE_WIDTH){rom_data_i[SAMPLE_WIDTH-1]}}, rom_data_i};

    // Volume multiply and arithmetic rescale; wide enough that nothing wraps before clamping.
    always_comb begin
        vol_ext = PRD_W'(volume_i);
        prod_l  = {{(PRD_W-ACC_W){acc_l[ACC_W-1]}}, acc_l} * vol_ext;
        prod_r  = {{(PRD_W-ACC_W){acc_r[ACC_W-1]}}, acc_r} * vol_ext;
        shr_l   = prod_l >>> (VOL_W - 1);
        shr_r   = prod_r >>> (VOL_W - 1);
    end

    // Frame sequencer: fetch slots, ROM drain, scale, single-cycle FIFO write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
            cnt   <= '0;
            out_l <= '0;
            out_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (audio_ena_i && !dac_fifo_almfull_i) begin
                        state <= S_FETCH;
                        cnt   <= '0;
                    end
                end
                S_FETCH: begin
                    if (cnt == CW'(VOICE_CNT - 1)) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt == CW'(ROM_LAT - 1)) begin
                        state <= S_SCALE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SCALE: begin
                    out_l <= sat(shr_l);
                    out_r <= sat(shr_r);
                    state <= S_WRITE;
                end
                S_WRITE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag pipeline follows each ROM read so the returning sample lands on the right channels.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag_vld <= '0;
            for (int i = 0; i < ROM_LAT; i++) tag_pan[i] <= 2'b00;
            acc_l <= '0;
            acc_r <= '0;
        end else begin
            tag_vld[0] <= fetch_rd;
            tag_pan[0] <= fetch_rd ? pan[slot] : 2'b00;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_pan[i] <= tag_pan[i-1];
            end
            if (state == S_WRITE) begin
                acc_l <= '0;
                acc_r <= '0;
            end else if (tag_vld[ROM_LAT-1]) begin
                if (tag_pan[ROM_LAT-1][1]) acc_l <= acc_l + samp_ext;
                if (tag_pan[ROM_LAT-1][0]) acc_r <= acc_r + samp_ext;
            end
        end
    end

    // Per-voice state: offset advance on its fetch slot, note commands override at the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int v = 0; v < VOICE_CNT; v++) begin
                jingle[v] <= '0;
                offset[v] <= '0;
                pan[v]    <= 2'b00;
            end
            loop_mode <= '0;
            active    <= '0;
        end else begin
            for (int v = 0; v < VOICE_CNT; v++) begin
                if (fetch_rd && (slot == VIW'(v))) begin
                    if (offset[v] == OW'(JINGLE_LEN - 1)) begin
                        offset[v] <= '0;
                        if (!loop_mode[v]) active[v] <= 1'b0;
                    end else begin
                        offset[v] <= offset[v] + OW'(1);
                    end
                end
                if (note_on_i && (note_voice_i == VIW'(v))) begin
                    jingle[v]    <= note_jingle_i;
                    loop_mode[v] <= note_loop_i;
                    pan[v]       <= note_pan_i;
                    offset[v]    <= '0;
                    active[v]    <= 1'b1;
                end else if (note_off_i && (note_voice_i == VIW'(v))) begin
                    active[v] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_voice_mixer
// Description : Directed self-checking bench for poly_voice_mixer with a
//               two-cycle-latency ROM model and an 8-sample jingle length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_voice_mixer;

    localparam int V  = 4;
    localparam int JC = 8;
    localparam int JL = 8;
    localparam int SW = 16;
    localparam int RL = 2;
    localparam int VW = 7;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          audio_ena, note_on, note_off, note_loop, almfull;
    logic [1:0]    note_voice;
    logic [2:0]    note_jingle;
    logic [1:0]    note_pan;
    logic [VW-1:0] volume;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [SW-1:0] rom_data;
    logic          samp_wr_req;
    logic [31:0]   lr;
    logic [V-1:0]  voice_active;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [SW-1:0] rom [0:63];
    logic          p1v = 1'b0, p2v = 1'b0;
    logic [AW-1:0] p1a = '0, p2a = '0;

    poly_voice_mixer #(
        .VOICE_CNT(V), .JINGLE_CNT(JC), .JINGLE_LEN(JL),
        .SAMPLE_WIDTH(SW), .ROM_LAT(RL), .VOL_W(VW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .audio_ena_i(audio_ena),
        .note_on_i(note_on), .note_off_i(note_off), .note_voice_i(note_voice),
        .note_jingle_i(note_jingle), .note_loop_i(note_loop), .note_pan_i(note_pan),
        .volume_i(volume), .rom_rd_o(rom_rd), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .dac_fifo_almfull_i(almfull),
        .samp_wr_req_o(samp_wr_req), .lr_chan_data_o(lr),
        .voice_active_o(voice_active), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // ROM model: data valid two cycles after the read strobe.
    always @(posedge clk) begin
        p1v <= rom_rd;
        p1a <= rom_addr;
        p2v <= p1v;
        p2a <= p1a;
    end
    assign rom_data = p2v ? rom[p2a] : '0;

    // Capture one frame: first read address, read count and the written pair.
    task automatic run_frame(output logic [31:0] data, output logic [AW-1:0] first_addr,
                             output int nreads, output bit got);
        got = 0; nreads = 0; first_addr = '0; data = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rom_rd) begin
                if (nreads == 0) first_addr = rom_addr;
                nreads++;
            end
            if (samp_wr_req) begin
                data = lr;
                got  = 1;
            end
        end
    endtask

    task automatic stop_audio();
        audio_ena = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
    endtask

    task automatic send_on(input int v, input int j, input bit lp, input logic [1:0] pn);
        @(negedge clk);
        note_on = 1'b1; note_voice = 2'(v); note_jingle = 3'(j); note_loop = lp; note_pan = pn;
        @(negedge clk);
        note_on = 1'b0;
    endtask

    task automatic send_off(input int v);
        @(negedge clk);
        note_off = 1'b1; note_voice = 2'(v);
        @(negedge clk);
        note_off = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (samp_wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", samp_wr_req); end
        n_chk++; if (voice_active !== 4'b0) begin n_fail++; $display("FAIL reset_active got %b want 0000", voice_active); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b want 0", rom_rd); end
        n_chk++; if (lr !== 32'h0) begin n_fail++; $display("FAIL reset_lr got %h want 0", lr); end
    endtask

    task automatic test_single_voice();
        logic [31:0] d; logic [AW-1:0] a; int n; bit g;
        rom[8] = 16'h1000; rom[9] = 16'h0200;
        send_on(0, 1, 1'b1, 2'b11);
        @(negedge clk); audio_ena = 1'b1;
        run_frame(d, a, n, g);
        n_chk++; if (!g || d !== 32'h1000_1000) begin n_fail++; $display("FAIL single_f1_data got %h want 10001000", d); end
        n_chk++; if (a !== 6'd8 || n != 1) begin n_fail++; $display("FAIL single_f1_addr got %0d/%0d want 8/1", a, n); end
        run_frame(d, a, n, g);
        n_chk++; if (!g || d !== 32'h0200_0200) begin n_fail++; $display("FAIL single_f2_data got %h want 02000200", d); end
        n_chk++; if (a !== 6'd9) begin n_fail++; $display("FAIL single_f2_addr got %0d want 9", a); end
        stop_audio();
    endtask

    task automatic test_saturation();
        logic [31:0] d; logic [AW-1:0] a; int n; bit g;
        for (int i = 16; i < 48; i++) rom[i] = 16'h7000;
        for (int v = 0; v < 4; v++) send_on(v, v + 2, 1'b1, 2'b11);
        @(negedge clk); audio_ena = 1'b1;
        run_frame(d, a, n, g);
        n_chk++; if (!g || d !== 32'h7FFF_7FFF) begin n_fail++; $display("FAIL sat_pos got %h want 7fff7fff", d); end
        n_chk++; if (n != 4) begin n_fail++; $display("FAIL sat_reads got %0d want 4", n); end
        stop_audio();
        for (int i = 16; i < 48; i++) rom[i] = 16'h9000;
        @(negedge clk); audio_ena = 1'b1;
        run_frame(d, a, n, g);
        n_chk++; if (!g || d !== 32'h8000_8000) begin n_fail++; $display("FAIL sat_neg got %h want 80008000", d); end
        stop_audio();
        for (int v = 0; v < 4; v++) send_off(v);
    endtask

    task automatic test_oneshot_and_loop();
        logic [31:0] d; logic [AW-1:0] a, a8; int n; bit g;
        for (int i = 0; i < 8; i++) rom[48 + i] = 16'(i + 1);
        for (int i = 0; i < 8; i++) rom[56 + i] = 16'(16 * (i + 1));
        send_on(0, 6, 1'b0, 2'b11);
        @(negedge clk); audio_ena = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            run_frame(d, a, n, g);
            n_chk++; if (!g || d !== {16'(k), 16'(k)}) begin n_fail++; $display("FAIL oneshot_f%0d got %h want %h", k, d, {16'(k), 16'(k)}); end
        end
        n_chk++; if (voice_active[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_active got %b want 0", voice_active[0]); end
        run_frame(d, a, n, g);
        n_chk++; if (!g || d !== 32'h0 || n != 0) begin n_fail++; $display("FAIL oneshot_f9 got %h/%0d want 0/0", d, n); end
        stop_audio();
        send_on(0, 7, 1'b1, 2'b11);
        @(negedge clk); audio_ena = 1'b1;
        a8 = '0;
        for (int k = 1; k <= 9; k++) begin
            run_frame(d, a, n, g);
            if (k == 8) a8 = a;
        end
        n_chk++; if (a8 !== 6'd63) begin n_fail++; $display("FAIL loop_addr8 got %0d want 63", a8); end
        n_chk++; if (!g || a !== 6'd56) begin n_fail++; $display("FAIL loop_addr9 got %0d want 56", a); end
        n_chk++; if (voice_active[0] !== 1'b1) begin n_fail++; $display("FAIL loop_active got %b want 1", voice_active[0]); end
    endtask

    task automatic test_almfull();
        logic [31:0] d; logic [AW-1:0] a; int n; bit g; int nrd, nwr, nbusy;
        almfull = 1'b1;
        nrd = 0; nwr = 0; nbusy = 0;
        repeat (100) begin
            @(negedge clk);
            if (rom_rd) nrd++;
            if (samp_wr_req) nwr++;
            if (busy) nbusy++;
        end
        n_chk++; if (nrd != 0 || nwr != 0) begin n_fail++; $display("FAIL almfull_hold got rd=%0d wr=%0d want 0/0", nrd, nwr); end
        n_chk++; if (nbusy > 1) begin n_fail++; $display("FAIL almfull_busy got %0d busy cycles want <=1", nbusy); end
        almfull = 1'b0;
        run_frame(d, a, n, g);
        n_chk++; if (!g || a !== 6'd57) begin n_fail++; $display("FAIL almfull_resume_addr got %0d want 57", a); end
        n_chk++; if (d !== 32'h0020_0020) begin n_fail++; $display("FAIL almfull_resume_data got %h want 00200020", d); end
        stop_audio();
        send_off(0);
    endtask

    task automatic test_on_off_same_cycle();
        logic [31:0] d; logic [AW-1:0] a; int n; bit g;
        for (int i = 8; i < 16; i++) rom[i] = 16'h0100;
        @(negedge clk);
        note_on = 1'b1; note_off = 1'b1; note_voice = 2'd2; note_jingle = 3'd1;
        note_loop = 1'b1; note_pan = 2'b10;
        @(negedge clk);
        note_on = 1'b0; note_off = 1'b0;
        n_chk++; if (voice_active !== 4'b0100) begin n_fail++; $display("FAIL onoff_active got %b want 0100", voice_active); end
        audio_ena = 1'b1;
        run_frame(d, a, n, g);
        n_chk++; if (!g || d !== 32'h0100_0000) begin n_fail++; $display("FAIL onoff_data got %h want 01000000", d); end
        stop_audio();
        send_off(2);
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        send_on(0, 1, 1'b1, 2'b11);
        send_on(1, 1, 1'b1, 2'b11);
        @(negedge clk); audio_ena = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rom_rd) seen = 1;
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL midrst_fetch got no read want read"); end
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (samp_wr_req !== 1'b0) begin n_fail++; $display("FAIL midrst_wr got %b want 0", samp_wr_req); end
        n_chk++; if (voice_active !== 4'b0) begin n_fail++; $display("FAIL midrst_active got %b want 0000", voice_active); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_chk++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_rd got %b want 0", rom_rd); end
        audio_ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rst_n = 1'b0; audio_ena = 1'b0; note_on = 1'b0; note_off = 1'b0;
        note_voice = '0; note_jingle = '0; note_loop = 1'b0; note_pan = 2'b00;
        almfull = 1'b0; volume = 7'd64;
        test_reset();
        test_single_voice();
        test_saturation();
        test_oneshot_and_loop();
        test_almfull();
        test_on_off_same_cycle();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
